alu_issue_unit: RTL and testbench

Request-side driver for the tensor core's `alu`: accepts tagged operations over a valid/ready handshake and issues at most one per cycle into the ALU. It tracks in-flight operations through the ALU's fixed latency and returns results in order over a second valid/ready interface, with credit-based back-pressure. It sits between the core's instruction sequencer and the `alu` instance.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_issue_result_fifo.sv | 79 +++++++
 rtl/alu_issue_unit.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the ALU issue path.
//   ALU_OPCODE_W    - opcode field width
//   alu_opcode_t    - ADD/SUB/MUL/EQ/GT encodings understood by the alu
//   is_legal_opcode - 1 for opcodes the alu implements (000..100)
package alu_pkg;

  localparam int unsigned ALU_OPCODE_W = 3;

  typedef enum logic [ALU_OPCODE_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_EQ  = 3'b011,
    ALU_GT  = 3'b100
  } alu_opcode_t;

  function automatic logic is_legal_opcode(input logic [ALU_OPCODE_W-1:0] op);
    return op <= ALU_OPCODE_W'(ALU_GT);
  endfunction

endpackage

// File: rtl/alu_issue_result_fifo.sv
// alu_issue_result_fifo: in-order buffer of {result, tag, illegal} entries.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   push_i/data_i  - write one entry
//   pop_i          - consume the head entry (ignored when empty)
//   head_o         - registered head entry, stable until popped
//   empty_o/full_o - registered status flags
//   count_o        - registered occupancy
module alu_issue_result_fifo #(
  parameter  int unsigned WIDTH = 13,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, full_q;
  logic             push_ok, pop_ok;

  // Next pointers/count; the head register is refilled from the entry that
  // will sit at the read pointer, bypassing the array when it is being written.
  always_comb begin
    pop_ok   = pop_i && !empty_q;
    push_ok  = push_i && (!full_q || pop_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_d   = head_q;
    if (push_ok && (count_q == CNT_W'(pop_ok))) begin
      head_d = push_data_i;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage array needs no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = head_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues tagged requests into the fixed-latency alu and
// returns results in order with credit-based back-pressure.
//   clock_in/reset_in      - clock, synchronous active-high reset
//   req_*                  - request valid/ready channel (opcode, operands, tag)
//   alu_*_out/alu_result_in- drive and observe the alu instance
//   rsp_*                  - response valid/ready channel (result, tag, illegal)
//   flush_in/flush_done_out- stop accepting, drain, pulse when empty
// Build option: ALU_ISSUE_ILLEGAL_CHECK_EN - opcodes 101..111 bypass the alu
// and return result 0 with rsp_illegal_out=1; otherwise every opcode is
// forwarded and rsp_illegal_out is always 0.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned TAG_WIDTH    = 4,
  parameter int unsigned ALU_LATENCY  = 1,
  parameter int unsigned RESULT_DEPTH = 4
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic [ALU_OPCODE_W-1:0] req_opcode_in,
  input  logic [DATA_WIDTH-1:0]   req_operand1_in,
  input  logic [DATA_WIDTH-1:0]   req_operand2_in,
  input  logic [TAG_WIDTH-1:0]    req_tag_in,
  output logic                    alu_enable_out,
  output logic [ALU_OPCODE_W-1:0] alu_opcode_out,
  output logic [DATA_WIDTH-1:0]   alu_input1_out,
  output logic [DATA_WIDTH-1:0]   alu_input2_out,
  input  logic [DATA_WIDTH-1:0]   alu_result_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [DATA_WIDTH-1:0]   rsp_result_out,
  output logic [TAG_WIDTH-1:0]    rsp_tag_out,
  output logic                    rsp_illegal_out,
  input  logic                    flush_in,
  output logic                    flush_done_out
);

  localparam int unsigned CNT_W   = $clog2(RESULT_DEPTH) + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + TAG_WIDTH + 1;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t                              state_q;
  logic [CNT_W-1:0]                    outstanding_q, outstanding_d;
  logic                                flush_done_q;
  logic                                accept, pop, issue_illegal;
  logic                                alu_en_q;
  logic [ALU_OPCODE_W-1:0]             alu_op_q;
  logic [DATA_WIDTH-1:0]               alu_in1_q, alu_in2_q;
  logic [ALU_LATENCY:0]                pipe_vld_q, pipe_ill_q;
  logic [ALU_LATENCY:0][TAG_WIDTH-1:0] pipe_tag_q;
  logic [DATA_WIDTH-1:0]               push_result;
  logic [ENTRY_W-1:0]                  fifo_head;
  logic                                fifo_empty, fifo_full;
  logic [CNT_W-1:0]                    fifo_count;

  // Credit check counts in-flight plus buffered ops, so the FIFO cannot overflow.
  assign req_ready_out = (outstanding_q < CNT_W'(RESULT_DEPTH)) && (state_q == ST_RUN) && !reset_in;
  assign accept        = req_valid_in && req_ready_out;
  assign pop           = rsp_valid_out && rsp_ready_in;

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  assign issue_illegal = !is_legal_opcode(req_opcode_in);
`else
  assign issue_illegal = 1'b0;
`endif

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !pop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  // Flush FSM and credit counter; the done pulse is raised on the edge where
  // the drain completes so it is visible in the cycle outstanding reads 0.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q       <= ST_RUN;
      outstanding_q <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      flush_done_q  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (flush_in) begin
            state_q      <= ST_DRAIN;
            flush_done_q <= (outstanding_d == '0);
          end
        end
        ST_DRAIN: begin
          if (outstanding_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            flush_done_q <= (outstanding_d == '0);
          end
        end
      endcase
    end
  end

  // Issue registers: operands captured on accept, enable is a one-cycle strobe.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else begin
      alu_en_q <= accept && !issue_illegal;
      if (accept) begin
        alu_op_q  <= req_opcode_in;
        alu_in1_q <= req_operand1_in;
        alu_in2_q <= req_operand2_in;
      end
    end
  end

  // Tag shadow pipeline aligned with the alu so the tail meets alu_result_in.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pipe_vld_q <= '0;
      pipe_ill_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_ill_q[0] <= issue_illegal;
      pipe_tag_q[0] <= req_tag_in;
      for (int i = 1; i <= int'(ALU_LATENCY); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_ill_q[i] <= pipe_ill_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign push_result = pipe_ill_q[ALU_LATENCY] ? '0 : alu_result_in;

  alu_issue_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clk_i       (clock_in),
    .rst_i       (reset_in),
    .push_i      (pipe_vld_q[ALU_LATENCY]),
    .push_data_i ({push_result, pipe_tag_q[ALU_LATENCY], pipe_ill_q[ALU_LATENCY]}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // Buffered results are always a subset of the credits handed out.
  assert property (@(posedge clock_in) disable iff (reset_in)
    !(pipe_vld_q[ALU_LATENCY] && fifo_full && !pop));
  assert property (@(posedge clock_in) disable iff (reset_in)
    fifo_count <= outstanding_q);

  assign alu_enable_out  = alu_en_q;
  assign alu_opcode_out  = alu_op_q;
  assign alu_input1_out  = alu_in1_q;
  assign alu_input2_out  = alu_in2_q;
  assign rsp_valid_out   = !fifo_empty;
  assign {rsp_result_out, rsp_tag_out, rsp_illegal_out} = fifo_head;
  assign flush_done_out  = flush_done_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: drives alu_issue_unit against a behavioural alu model
// and checks responses through a scoreboard queue.
module tb_alu_issue_unit;

  localparam int unsigned DW    = 8;
  localparam int unsigned TW    = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_in, req_valid_in, req_ready_out;
  logic [2:0]    req_opcode_in;
  logic [DW-1:0] req_operand1_in, req_operand2_in;
  logic [TW-1:0] req_tag_in;
  logic          alu_enable_out;
  logic [2:0]    alu_opcode_out;
  logic [DW-1:0] alu_input1_out, alu_input2_out, alu_result_in;
  logic          rsp_valid_out, rsp_ready_in;
  logic [DW-1:0] rsp_result_out;
  logic [TW-1:0] rsp_tag_out;
  logic          rsp_illegal_out, flush_in, flush_done_out;

  alu_issue_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .ALU_LATENCY(LAT), .RESULT_DEPTH(DEPTH)) dut (
    .clock_in(clk), .reset_in(reset_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_opcode_in(req_opcode_in), .req_operand1_in(req_operand1_in),
    .req_operand2_in(req_operand2_in), .req_tag_in(req_tag_in),
    .alu_enable_out(alu_enable_out), .alu_opcode_out(alu_opcode_out),
    .alu_input1_out(alu_input1_out), .alu_input2_out(alu_input2_out),
    .alu_result_in(alu_result_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_result_out(rsp_result_out), .rsp_tag_out(rsp_tag_out),
    .rsp_illegal_out(rsp_illegal_out),
    .flush_in(flush_in), .flush_done_out(flush_done_out)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] op; logic [DW-1:0] a; logic [DW-1:0] b; logic [TW-1:0] tag;} req_t;
  typedef struct {logic [DW-1:0] res; logic [TW-1:0] tag; logic ill; int acc_cyc; bit strict;} exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   acc_cnt = 0, pop_cnt = 0, last_pop_cyc = 0;
  bit   lat_strict = 1'b0, rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour of the alu: signed arithmetic truncated to DW bits.
  function automatic logic [DW-1:0] ref_res(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return DW'(sa + sb);
      3'd1:    return DW'(sa - sb);
      3'd2:    return DW'(sa * sb);
      3'd3:    return (sa == sb) ? DW'(1) : DW'(0);
      3'd4:    return (sa > sb) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.tag = tag;
    req_q.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", longint'(n < budget), 1);
  endtask

  // Behavioural alu instance: samples on enable, result after LAT edges.
  logic [DW-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    if (alu_enable_out) alu_pipe[0] <= ref_res(alu_opcode_out, alu_input1_out, alu_input2_out);
    for (int i = 1; i < int'(LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result_in = alu_pipe[LAT-1];

  // Request driver: presents req_q head, records expectations on accept.
  initial begin : driver
    bit   acc;
    bit   en_exp;
    req_t last;
    exp_t e;
    en_exp = 1'b0;
    req_valid_in = 1'b0; req_opcode_in = '0; req_operand1_in = '0; req_operand2_in = '0; req_tag_in = '0;
    forever begin
      @(negedge clk);
      chk("alu_enable", alu_enable_out, en_exp);
      if (en_exp) begin
        chk("alu_opcode", alu_opcode_out, last.op);
        chk("alu_input1", alu_input1_out, last.a);
        chk("alu_input2", alu_input2_out, last.b);
      end
      acc = req_valid_in && req_ready_out;
      en_exp = 1'b0;
      if (acc) begin
        last   = req_q[0];
        en_exp = !ILL_EN || legal(last.op);
        e.ill  = ILL_EN && !legal(last.op);
        e.res  = e.ill ? '0 : ref_res(last.op, last.a, last.b);
        e.tag  = last.tag;
        e.acc_cyc = cyc;
        e.strict  = lat_strict;
        exp_q.push_back(e);
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (acc) void'(req_q.pop_front());
      if (req_q.size() != 0) begin
        req_valid_in    = 1'b1;
        req_opcode_in   = req_q[0].op;
        req_operand1_in = req_q[0].a;
        req_operand2_in = req_q[0].b;
        req_tag_in      = req_q[0].tag;
      end else begin
        req_valid_in = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  initial begin : monitor
    exp_t e;
    logic [DW+TW+1:0] prev;
    bit held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (held && !reset_in)
        chk("rsp_stable", {rsp_valid_out, rsp_result_out, rsp_tag_out, rsp_illegal_out}, prev);
      held = rsp_valid_out && !rsp_ready_in && !reset_in;
      prev = {rsp_valid_out, rsp_result_out, rsp_tag_out, rsp_illegal_out};
      if (rsp_valid_out && rsp_ready_in) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result_tag_ill", {rsp_result_out, rsp_tag_out, rsp_illegal_out}, {e.res, e.tag, e.ill});
          if (e.strict) chk("rsp_latency", cyc - e.acc_cyc, 2 + LAT);
          else          chk("rsp_latency_min", longint'(cyc - e.acc_cyc >= int'(2 + LAT)), 1);
        end
      end
    end
  end

  // Random consumer readiness and occasional flushes during the random phase.
  initial begin : rand_ctl
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        rsp_ready_in = ($urandom_range(0, 3) != 0);
        flush_in     = ($urandom_range(0, 31) == 0);
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, req_ready_out, 1);
    chk({tag, "_alu_en"}, alu_enable_out, 0);
    chk({tag, "_alu_ops"}, {alu_opcode_out, alu_input1_out, alu_input2_out}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_out, 0);
    chk({tag, "_rsp_fields"}, {rsp_result_out, rsp_tag_out, rsp_illegal_out}, 0);
    chk({tag, "_flush_done"}, flush_done_out, 0);
  endtask

  initial begin : main
    int base, pops0, n;
    reset_in = 1'b1; rsp_ready_in = 1'b0; flush_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", req_ready_out, 0);
    @(posedge clk); #1 reset_in = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // Directed arithmetic incl. wrap, sub/mul/eq/gt back-to-back.
    lat_strict = 1'b1;
    rsp_ready_in = 1'b1;
    send(3'd0, 8'd100, 8'd27, 4'd3);
    send(3'd0, 8'd100, 8'd28, 4'd3);
    wait_idle(50);
    send(3'd1, 8'd5, 8'd9, 4'd0);
    send(3'd2, 8'd16, 8'd16, 4'd1);
    send(3'd3, 8'd7, 8'd7, 4'd2);
    send(3'd4, 8'hFF, 8'd2, 4'd3);
    wait_idle(50);

    // Back-pressure: 6 offered, only DEPTH accepted while consumer stalls.
    lat_strict = 1'b0;
    @(posedge clk); #1 rsp_ready_in = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) send(3'(i % 5), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i));
    repeat (10) @(negedge clk);
    chk("bp_accepted", acc_cnt - base, DEPTH);
    chk("bp_ready_low", req_ready_out, 0);
    chk("bp_rsp_valid", rsp_valid_out, 1);
    @(posedge clk); #1 rsp_ready_in = 1'b1;
    wait_idle(100);
    chk("bp_all_accepted", acc_cnt - base, 6);

    // Flush with two ops outstanding.
    @(posedge clk); #1 rsp_ready_in = 1'b0;
    base = acc_cnt;
    send(3'd0, 8'd1, 8'd2, 4'd5);
    send(3'd1, 8'd9, 8'd4, 4'd6);
    n = 0;
    while (acc_cnt - base < 2 && n < 20) begin @(negedge clk); n++; end
    chk("flush_setup_accepts", acc_cnt - base, 2);
    repeat (4) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk);
    chk("flush_ready_low", req_ready_out, 0);
    chk("flush_done_early", flush_done_out, 0);
    @(posedge clk); #1 flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0; rsp_ready_in = 1'b1;
    pops0 = pop_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (!flush_done_out && n < 20);
    chk("flush_done_seen", flush_done_out, 1);
    chk("flush_done_timing", cyc, last_pop_cyc + 1);
    chk("flush_pops", pop_cnt - pops0, 2);
    chk("flush_drain_ready", req_ready_out, 0);
    @(negedge clk);
    chk("flush_ready_back", req_ready_out, 1);
    chk("flush_done_pulse", flush_done_out, 0);

    // Flush with nothing outstanding: one cycle in drain.
    @(posedge clk); #1 flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk);
    chk("flush0_done", flush_done_out, 1);
    chk("flush0_ready", req_ready_out, 0);
    @(negedge clk);
    chk("flush0_done_off", flush_done_out, 0);
    chk("flush0_ready_back", req_ready_out, 1);

    // Reset with three ops in flight: all discarded.
    @(posedge clk); #1 rsp_ready_in = 1'b0;
    base = acc_cnt;
    send(3'd0, 8'd3, 8'd4, 4'd7);
    send(3'd2, 8'd3, 8'd4, 4'd8);
    send(3'd1, 8'd3, 8'd4, 4'd9);
    n = 0;
    while (acc_cnt - base < 3 && n < 20) begin @(negedge clk); n++; end
    chk("reset_setup_accepts", acc_cnt - base, 3);
    @(posedge clk); #1 reset_in = 1'b1;
    @(posedge clk); #1 reset_in = 1'b0;
    exp_q.delete();
    rsp_ready_in = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    n = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid_out) n++; end
    chk("reset_no_rsp", n, 0);

    // Illegal opcode.
    lat_strict = 1'b1;
    send(3'b110, 8'd5, 8'd6, 4'd9);
    send(3'b111, 8'd1, 8'd1, 4'd10);
    wait_idle(50);

    // Sustained throughput with consumer always ready.
    for (int i = 0; i < 20; i++)
      send(3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 4'($urandom));
    wait_idle(100);

    // Random traffic with random back-pressure and flushes.
    lat_strict = 1'b0;
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++)
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'($urandom));
    n = 0;
    while (req_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1 rand_mode = 1'b0;
    @(posedge clk); #1 rsp_ready_in = 1'b1; flush_in = 1'b0;
    wait_idle(2000);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
